// File: rtl/pri_arbiter8.sv
// Eight-way arbiter with registered, held grants.
// Fixed or round-robin high-index-first selection, with an optional hold-time limit.
module pri_arbiter8 #(
  parameter int unsigned MODE     = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned HW = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  gnt_nx;
  logic [IW-1:0] gnt_id_nx;
  logic          gnt_valid_nx;
  logic          preempt_nx;
  logic [IW-1:0] last_id, last_id_nx;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;

  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          drop, expire;

  // Winner search; later loop iterations overwrite earlier ones, so the last hit wins.
  always_comb begin
    win = '0;
    idx = '0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) win = IW'(i);
      end
    end else begin
      // Visit last_id (lowest priority) first and last_id-1 (highest) last.
      for (int i = int'(N); i >= 1; i--) begin
        idx = IW'(int'(last_id) - i);
        if (req[idx]) win = idx;
      end
    end
  end

  assign drop   = ~req[gnt_id];
  assign expire = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      last_id   <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_id    <= gnt_id_nx;
      gnt_valid <= gnt_valid_nx;
      preempt   <= preempt_nx;
      last_id   <= last_id_nx;
      hold_cnt  <= hold_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    gnt_id_nx    = gnt_id;
    gnt_valid_nx = gnt_valid;
    preempt_nx   = 1'b0;
    last_id_nx   = last_id;
    hold_cnt_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx     = GRANT;
          gnt_nx       = N'(1) << win;
          gnt_id_nx    = win;
          gnt_valid_nx = 1'b1;
          hold_cnt_nx  = HW'(1);
          last_id_nx   = win;
        end else begin
          gnt_nx       = '0;
          gnt_id_nx    = '0;
          gnt_valid_nx = 1'b0;
          hold_cnt_nx  = '0;
        end
      end
      GRANT: begin
        if (drop || done || expire) begin
          // Preempt only flags a release caused purely by the hold limit.
          state_nx     = IDLE;
          gnt_nx       = '0;
          gnt_id_nx    = '0;
          gnt_valid_nx = 1'b0;
          hold_cnt_nx  = '0;
          preempt_nx   = expire && !drop && !done;
        end else if (hold_cnt != {HW{1'b1}}) begin
          hold_cnt_nx = HW'(hold_cnt + HW'(1));
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pri_arbiter8.sv
// Directed bench: a round-robin/hold-limit instance driven from a vector table,
// plus a fixed-priority unlimited-hold instance and an asynchronous reset sequence.
module tb_pri_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  logic [7:0] a_gnt, b_gnt;
  logic [2:0] a_id, b_id;
  logic       a_valid, b_valid, a_pre, b_pre;

  int checks;
  int failures;

  pri_arbiter8 #(.MODE(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(a_gnt), .gnt_id(a_id), .gnt_valid(a_valid), .preempt(a_pre)
  );

  pri_arbiter8 #(.MODE(0), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(b_gnt), .gnt_id(b_id), .gnt_valid(b_valid), .preempt(b_pre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                     input logic [2:0] id, input logic v, input logic p);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.id = id; e.valid = v; e.pre = p;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    done     = 1'b0;

    do_reset();
    chk("reset_gnt",     32'(a_gnt),   32'h0);
    chk("reset_valid",   32'(a_valid), 32'h0);
    chk("reset_id",      32'(a_id),    32'h0);
    chk("reset_preempt", 32'(a_pre),   32'h0);

    // Round-robin over all-requesting vector: 7,6,...,0,7 with an idle gap each time.
    for (int k = 0; k < 9; k++) begin
      int id;
      id = (15 - k) % 8;
      add(8'hFF, 1'b0, 8'(1) << id, 3'(id), 1'b1, 1'b0);
      add((k == 8) ? 8'h00 : 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    end
    // Hold limit 4: four granted cycles, then one preempted idle cycle, then regrant.
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    // done coinciding with expiry: release without preempt.
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    // done while idle with no requests changes nothing.
    add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // Owner 3 drops its request while 5 waits.
    add(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("rr_gnt[%0d]", i),     32'(a_gnt),   32'(tbl[i].gnt));
      chk($sformatf("rr_valid[%0d]", i),   32'(a_valid), 32'(tbl[i].valid));
      chk($sformatf("rr_preempt[%0d]", i), 32'(a_pre),   32'(tbl[i].pre));
      if (tbl[i].valid)
        chk($sformatf("rr_id[%0d]", i), 32'(a_id), 32'(tbl[i].id));
    end

    // Asynchronous reset mid-grant (gnt=8'h20) clears outputs before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt",   32'(a_gnt),   32'h0);
    chk("async_rst_valid", 32'(a_valid), 32'h0);
    chk("async_rst_pre",   32'(a_pre),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'hFF, 1'b0);
    chk("post_rst_id",  32'(a_id),  32'd7);
    chk("post_rst_gnt", 32'(a_gnt), 32'h80);

    // Fixed priority, req=8'h12 held: owner 4 every time, idle cycle between grants.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(8'h12, 1'b0);
      chk($sformatf("fx_id[%0d]", k),    32'(b_id),    32'd4);
      chk($sformatf("fx_gnt[%0d]", k),   32'(b_gnt),   32'h10);
      chk($sformatf("fx_valid[%0d]", k), 32'(b_valid), 32'h1);
      step(8'h12, 1'b1);
      chk($sformatf("fx_idle[%0d]", k),  32'(b_gnt),   32'h0);
    end
    // Unlimited hold: grant persists well past any limit.
    step(8'h12, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(8'h12, 1'b0);
      chk($sformatf("fx_hold[%0d]", k), 32'({b_valid, b_pre, b_gnt}), 32'({1'b1, 1'b0, 8'h10}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
